dqsw_wl_training_ctrl: RTL and testbench
========================================

Name: dqsw_wl_training_ctrl

Overview:
- Write-levelling training controller for one DDR3 byte lane's DQSW/DQSW270 IOD.
- Drives the IOD's dynamic delay-line controls: load, move and direction.
- Requests write-levelling DQS pulses, then samples the DQ feedback returned through the lane's RX_DATA.
- Finds the first delay tap at which the DRAM reports CK sampled high, qualified by consecutive-sample voting, and reports the tap or an error to the PHY training sequencer.

Parameters:
- TAP_W, 8, width of tap counter and TAP_VALUE.
- MAX_TAP, 127, highest tap allowed; reaching it without a qualified edge is an error.
- SETTLE_CYCLES, 8, FAB_CLK cycles waited after delay-line load/move before pulsing DQS.
- FB_LATENCY, 16, FAB_CLK cycles from WL_PULSE to valid feedback on RX_DATA.
- VOTES, 3, consecutive 1-samples (after a 0 has been seen) required to accept an edge; 1..15.

Ports:
- FAB_CLK  in  1  fabric clock; all logic is on its rising edge.
- ARST_N  in  1  asynchronous active-low reset.
- TRAIN_START  in  1  level; sampled in IDLE, DONE and ERR.
- TRAIN_BUSY  out  1  high from LOAD through the final SAMPLE/STEP.
- TRAIN_DONE  out  1  sticky success flag.
- TRAIN_ERR  out  1  sticky failure flag.
- TAP_VALUE  out  TAP_W  live tap while busy; result after DONE; failing tap after ERR.
- DELAY_LINE_LOAD  out  1  one-cycle pulse; resets the IOD delay line to tap 0.
- DELAY_LINE_MOVE  out  1  one-cycle pulse; steps the delay line by one tap.
- DELAY_LINE_DIRECTION  out  1  1 = increment; driven 1 only during MOVE, else 0.
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line limit flag.
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse, issued with LOAD.
- WL_PULSE  out  1  one-cycle request to the lane TX path to emit a write-levelling DQS pulse.
- RX_DATA  in  2  DQ feedback, both phases.

Behaviour:
Clocking and reset:
- Single clock domain.
- ARST_N low asynchronously forces: state to IDLE, all outputs to 0, all counters to 0.
- Reset in any state aborts training; no further LOAD/MOVE is issued until a new start.

FSM states: IDLE, LOAD, SETTLE, PULSE, WAIT_FB, SAMPLE, STEP, DONE, ERR.
- IDLE:
  - TRAIN_START=1 -> LOAD.
- LOAD (1 cycle):
  - DELAY_LINE_LOAD=1 and EYE_MONITOR_CLEAR_FLAGS=1.
  - tap=0, seen_zero=0, ones=0, DONE and ERR flags cleared, BUSY=1.
  - Next: SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES cycles, then -> PULSE.
- PULSE (1 cycle):
  - WL_PULSE=1.
  - Next: WAIT_FB.
- WAIT_FB:
  - Count FB_LATENCY cycles, then -> SAMPLE.
- SAMPLE (1 cycle): fb = RX_DATA[1] & RX_DATA[0].
  - fb=0: seen_zero=1, ones=0; -> STEP.
  - fb=1 and seen_zero=0: no change (training started inside the high region; keep searching for a rising edge); -> STEP.
  - fb=1 and seen_zero=1: ones+1. If ones+1==VOTES, TAP_VALUE=tap-(VOTES-1) -> DONE; else -> STEP.
- STEP (1 cycle):
  - If DELAY_LINE_OUT_OF_RANGE=1 or tap==MAX_TAP: no MOVE issued; TAP_VALUE=tap; -> ERR.
  - Otherwise: DELAY_LINE_MOVE=1, DELAY_LINE_DIRECTION=1, tap+1; -> SETTLE.
- DONE / ERR:
  - BUSY=0; the respective flag is held at 1.
  - TRAIN_START=1 -> LOAD (flags clear in LOAD).
  - TRAIN_START=1 while BUSY is ignored.

Timing:
- First SAMPLE occurs 1+SETTLE+1+FB_LATENCY cycles after LOAD, i.e. 26 cycles with defaults.
- Each subsequent tap costs 1+SETTLE+1+FB_LATENCY+1 cycles, i.e. 27 cycles with defaults.

Invariants:
- At most one of LOAD, MOVE and WL_PULSE is high in any cycle.
- The tap counter never wraps.
- DONE and ERR are never high together.

Test Plan:
- Feedback model: fb=1 for tap>=40, 0 below. Pulse START -> 42 MOVE pulses, DONE=1, TAP_VALUE=40, ERR=0, BUSY=0.
- Feedback 1 at tap 20 only, then 1 for tap>=50 -> the glitch at tap 20 is rejected by voting; DONE with TAP_VALUE=50.
- Feedback always 1 -> no 0 is ever seen; 127 MOVE pulses, ERR=1, TAP_VALUE=127, no MOVE after ERR.
- DELAY_LINE_OUT_OF_RANGE forced high once tap reaches 10, feedback always 0 -> ERR=1, TAP_VALUE=10, exactly 10 MOVE pulses.
- ARST_N low during WAIT_FB at tap 5 -> all outputs 0 in the same cycle. Release reset and start again -> LOAD pulse is reissued and the sequence completes with the first scenario's result.
- START re-pulsed while BUSY -> ignored, no second LOAD. START in DONE -> DONE clears and a new LOAD is issued; WL_PULSE count per tap is exactly 1.

Source files
------------

// File: rtl/dqsw_wl_training_ctrl.sv
// -----------------------------------------------------------------------------
// dqsw_wl_training_ctrl
//
// Write-levelling training controller for one DDR3 byte lane's DQSW/DQSW270
// IOD. It resets the IOD delay line to tap 0, then for each tap it waits for
// the line to settle, requests one write-levelling DQS pulse, waits for the DQ
// feedback and samples it. The first tap of a run of VOTES consecutive
// "CK high" samples that follows a "CK low" sample is reported as the result.
// Running out of taps, or the IOD flagging its limit, ends in an error.
//
// Ports
//   FAB_CLK                  fabric clock, rising edge
//   ARST_N                   asynchronous active-low reset
//   TRAIN_START              start request (level), honoured in IDLE/DONE/ERR
//   TRAIN_BUSY               training in progress (LOAD .. final SAMPLE/STEP)
//   TRAIN_DONE / TRAIN_ERR   sticky result flags, cleared by the next LOAD
//   TAP_VALUE                live tap while busy, result/failing tap after
//   DELAY_LINE_LOAD          1-cycle pulse, delay line back to tap 0
//   DELAY_LINE_MOVE          1-cycle pulse, step delay line by one tap
//   DELAY_LINE_DIRECTION     1 = increment, only asserted together with MOVE
//   DELAY_LINE_OUT_OF_RANGE  IOD delay-line limit flag
//   EYE_MONITOR_CLEAR_FLAGS  1-cycle pulse issued with LOAD
//   WL_PULSE                 1-cycle request for one write-levelling DQS pulse
//   RX_DATA                  DQ feedback, both phases
// -----------------------------------------------------------------------------
module dqsw_wl_training_ctrl #(
  parameter int TAP_W         = 8,
  parameter int MAX_TAP       = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int FB_LATENCY    = 16,
  parameter int VOTES         = 3
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             TRAIN_START,
  output logic             TRAIN_BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_ERR,
  output logic [TAP_W-1:0] TAP_VALUE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             WL_PULSE,
  input  logic [1:0]       RX_DATA
);

  localparam int CNT_MAX = (SETTLE_CYCLES > FB_LATENCY) ? SETTLE_CYCLES : FB_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_SETTLE  = 4'd2,
    S_PULSE   = 4'd3,
    S_WAIT_FB = 4'd4,
    S_SAMPLE  = 4'd5,
    S_STEP    = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic               seen_zero_q, seen_zero_d;
  logic [3:0]         ones_q, ones_d;
  logic [3:0]         ones_inc_s;
  logic               fb_s;
  logic               step_ok_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               load_q, load_d;
  logic               move_q, move_d;
  logic               dir_q, dir_d;
  logic               clr_q, clr_d;
  logic               pulse_q, pulse_d;

  assign fb_s       = RX_DATA[1] & RX_DATA[0];
  assign ones_inc_s = ones_q + 4'd1;

  // Next-state, counter and tap/vote bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tap_d       = tap_q;
    seen_zero_d = seen_zero_q;
    ones_d      = ones_q;
    step_ok_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (TRAIN_START) state_d = S_LOAD;
        else             state_d = S_IDLE;
      end
      S_LOAD: begin
        tap_d       = {TAP_W{1'b0}};
        seen_zero_d = 1'b0;
        ones_d      = 4'd0;
        cnt_d       = {CNT_W{1'b0}};
        state_d     = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_PULSE;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_PULSE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_WAIT_FB;
      end
      S_WAIT_FB: begin
        if (cnt_q == CNT_W'(FB_LATENCY - 1)) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_SAMPLE;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_SAMPLE: begin
        // The move/no-move decision is latched here so MOVE can come straight
        // from a flop in STEP. The limit flag only changes after a move and has
        // had the whole settle/feedback window to become stable by now.
        step_ok_d = ~DELAY_LINE_OUT_OF_RANGE & (tap_q != TAP_W'(MAX_TAP));
        if (!fb_s) begin
          seen_zero_d = 1'b1;
          ones_d      = 4'd0;
          state_d     = S_STEP;
        end else if (!seen_zero_q) begin
          // Started inside the high region: keep looking for a rising edge.
          state_d     = S_STEP;
        end else if (ones_inc_s == 4'(VOTES)) begin
          // Report the first tap of the qualifying run of 1-samples.
          ones_d      = ones_inc_s;
          tap_d       = tap_q - TAP_W'(VOTES - 1);
          step_ok_d   = 1'b0;
          state_d     = S_DONE;
        end else begin
          ones_d      = ones_inc_s;
          state_d     = S_STEP;
        end
      end
      S_STEP: begin
        if (move_q) begin
          tap_d   = tap_q + {{(TAP_W-1){1'b0}}, 1'b1};
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_SETTLE;
        end else begin
          state_d = S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (TRAIN_START) state_d = S_LOAD;
        else             state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flops are loaded from the state being entered so every output is registered.
  always_comb begin
    load_d  = (state_d == S_LOAD);
    clr_d   = (state_d == S_LOAD);
    pulse_d = (state_d == S_PULSE);
    move_d  = (state_d == S_STEP) & step_ok_d;
    dir_d   = (state_d == S_STEP) & step_ok_d;
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    busy_d  = (state_d != S_IDLE) & (state_d != S_DONE) & (state_d != S_ERR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      tap_q       <= {TAP_W{1'b0}};
      seen_zero_q <= 1'b0;
      ones_q      <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_q      <= 1'b0;
      move_q      <= 1'b0;
      dir_q       <= 1'b0;
      clr_q       <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tap_q       <= tap_d;
      seen_zero_q <= seen_zero_d;
      ones_q      <= ones_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      load_q      <= load_d;
      move_q      <= move_d;
      dir_q       <= dir_d;
      clr_q       <= clr_d;
      pulse_q     <= pulse_d;
    end
  end

  assign TRAIN_BUSY              = busy_q;
  assign TRAIN_DONE              = done_q;
  assign TRAIN_ERR               = err_q;
  assign TAP_VALUE               = tap_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
  assign WL_PULSE                = pulse_q;

endmodule

// File: tb/tb_dqsw_wl_training_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for dqsw_wl_training_ctrl: a tap-indexed feedback model drives RX_DATA,
// a table of scenarios is run back to back with expected results queued at
// start and checked on completion, plus hand-written reset and start cases.
// -----------------------------------------------------------------------------
module tb_dqsw_wl_training_ctrl;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N;
  logic       TRAIN_START;
  logic       TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR;
  logic [7:0] TAP_VALUE;
  logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic       EYE_MONITOR_CLEAR_FLAGS, WL_PULSE;
  logic [1:0] RX_DATA;

  always #5 FAB_CLK = ~FAB_CLK;

  dqsw_wl_training_ctrl dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .TRAIN_START             (TRAIN_START),
    .TRAIN_BUSY              (TRAIN_BUSY),
    .TRAIN_DONE              (TRAIN_DONE),
    .TRAIN_ERR               (TRAIN_ERR),
    .TAP_VALUE               (TAP_VALUE),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
    .WL_PULSE                (WL_PULSE),
    .RX_DATA                 (RX_DATA)
  );

  // Feedback model: mode 0 edge at 40, mode 1 glitch at 20 + edge at 50,
  // mode 2 always high, mode 3 always low. Low samples use a single-phase 1
  // so only the AND of both phases reads as high.
  int mode    = 3;
  int oor_tap = -1;

  function automatic bit fb_model(int m, int t);
    case (m)
      0:       return t >= 40;
      1:       return (t == 20) || (t >= 50);
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign RX_DATA = fb_model(mode, int'(TAP_VALUE)) ? 2'b11 :
                   (TAP_VALUE[0] ? 2'b10 : 2'b01);
  assign DELAY_LINE_OUT_OF_RANGE = (oor_tap >= 0) && (int'(TAP_VALUE) >= oor_tap);

  // Activity monitor, sampled on the inactive edge.
  int n_load = 0, n_move = 0, n_pulse = 0, n_busy = 0;
  int inv_err = 0, pulse_err = 0, pulses_this_tap = 0;

  always @(negedge FAB_CLK) begin
    if (DELAY_LINE_LOAD) begin
      n_load          <= n_load + 1;
      pulses_this_tap <= 0;
    end else if (WL_PULSE) begin
      n_pulse         <= n_pulse + 1;
      pulses_this_tap <= pulses_this_tap + 1;
    end else if (DELAY_LINE_MOVE) begin
      n_move          <= n_move + 1;
      pulses_this_tap <= 0;
      if (pulses_this_tap != 1) pulse_err <= pulse_err + 1;
    end
    if (TRAIN_BUSY) n_busy <= n_busy + 1;
    if ((int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(WL_PULSE) > 1) ||
        (TRAIN_DONE && TRAIN_ERR) || (DELAY_LINE_DIRECTION != DELAY_LINE_MOVE))
      inv_err <= inv_err + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int mode;
    int oor_tap;
    int exp_done;
    int exp_err;
    int exp_tap;
    int exp_moves;
    int exp_busy;   // busy cycles: LOAD through final SAMPLE/STEP
  } vec_t;

  vec_t vecs[4];
  vec_t exp_q[$];

  function automatic int all_outputs();
    return int'({TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                 DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS, WL_PULSE, TAP_VALUE});
  endfunction

  // Start a run (from IDLE/DONE/ERR), hold START a few cycles and re-pulse it mid-run.
  task automatic start_run();
    @(negedge FAB_CLK);
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    check("load_pulse", int'(DELAY_LINE_LOAD), 1);
    check("clear_pulse", int'(EYE_MONITOR_CLEAR_FLAGS), 1);
    check("busy_on_load", int'(TRAIN_BUSY), 1);
    check("flags_cleared", int'({TRAIN_DONE, TRAIN_ERR}), 0);
    repeat (3) @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
    repeat (100) @(negedge FAB_CLK);
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge FAB_CLK);
      if (!TRAIN_BUSY) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Run one scenario and score it against the queued expectation.
  task automatic run_vec(vec_t v, string tag);
    int l0, m0, b0;
    bit ok;
    vec_t e;
    mode    = v.mode;
    oor_tap = v.oor_tap;
    l0 = n_load; m0 = n_move; b0 = n_busy;
    exp_q.push_back(v);
    start_run();
    wait_idle(ok);
    check({tag, "_finished"}, int'(ok), 1);
    e = exp_q.pop_front();
    check({tag, "_done"}, int'(TRAIN_DONE), e.exp_done);
    check({tag, "_err"}, int'(TRAIN_ERR), e.exp_err);
    check({tag, "_tap"}, int'(TAP_VALUE), e.exp_tap);
    check({tag, "_moves"}, n_move - m0, e.exp_moves);
    check({tag, "_loads"}, n_load - l0, 1);
    check({tag, "_busy_cycles"}, n_busy - b0, e.exp_busy);
    check({tag, "_last_tap_pulses"}, pulses_this_tap, 1);
    m0 = n_move;
    repeat (40) @(negedge FAB_CLK);
    check({tag, "_no_move_after"}, n_move - m0, 0);
    check({tag, "_flag_held"}, int'({TRAIN_DONE, TRAIN_ERR}), 2 * e.exp_done + e.exp_err);
  endtask

  initial begin
    bit found;
    int m0, l0;
    //          mode oor  done err tap moves busy
    vecs[0] = '{0,   -1,  1,   0,  40,  42,  1161};
    vecs[1] = '{1,   -1,  1,   0,  50,  52,  1431};
    vecs[2] = '{2,   -1,  0,   1,  127, 127, 3457};
    vecs[3] = '{3,   10,  0,   1,  10,  10,  298};

    ARST_N      = 1'b0;
    TRAIN_START = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    check("reset_outputs", all_outputs(), 0);
    ARST_N = 1'b1;
    @(negedge FAB_CLK);
    check("idle_outputs", all_outputs(), 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset while waiting for feedback at tap 5.
    mode    = 0;
    oor_tap = -1;
    start_run();
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge FAB_CLK);
      if (WL_PULSE && TAP_VALUE == 8'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_tap5_wait", int'(found), 1);
    repeat (2) @(negedge FAB_CLK);
    #2 ARST_N = 1'b0;
    #1 check("async_reset_outputs", all_outputs(), 0);
    m0 = n_move; l0 = n_load;
    repeat (5) @(negedge FAB_CLK);
    check("reset_no_activity", (n_move - m0) + (n_load - l0), 0);
    ARST_N = 1'b1;
    repeat (3) @(negedge FAB_CLK);
    check("after_reset_idle", all_outputs(), 0);
    run_vec(vecs[0], "restart");

    check("one_pulse_per_tap", pulse_err, 0);
    check("invariants", inv_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
